// File: rtl/cbus_rr_arbiter.sv
// Round-robin CBus arbiter: locks one requester for a whole burst, releases on the handshaked last beat.
// Latency: one registered arbitration cycle, then a combinational pass-through; non-owners see an all-zero response.
package cbus_pkg;
  typedef logic [3:0] cbus_len_t;
  localparam cbus_len_t MLEN1  = 4'd0;
  localparam cbus_len_t MLEN4  = 4'd3;
  localparam cbus_len_t MLEN8  = 4'd7;
  localparam cbus_len_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    cbus_len_t   len;
    logic [31:0] data;
    logic [3:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic       [IDX_W-1:0]      grant_idx,
  output logic                        busy,
  output logic                        protocol_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [4:0]       beats_q, beats_d;
  logic             err_q, err_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx, cand, sel_inc;
  logic [4:0]       beats_inc, exp_beats;
  cbus_req_t        cur_req;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(prio_q) + k) % NUM_INPUTS);
      if (ireqs[cand].valid) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    cur_req   = ireqs[sel_q];
    sel_inc   = (sel_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_q + IDX_W'(1);
    beats_inc = beats_q + 5'd1;
    exp_beats = {1'b0, cur_req.len} + 5'd1;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    beats_d = beats_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_BUSY;
          sel_d   = win_idx;
          beats_d = '0;
        end
      end
      S_BUSY: begin
        // A drop of valid is only honoured before the first beat; later drops are ignored.
        if (!cur_req.valid && beats_q == 5'd0) begin
          state_d = S_IDLE;
        end else if (oresp.ready) begin
          beats_d = beats_inc;
          if (oresp.last) begin
            state_d = S_IDLE;
            prio_d  = sel_inc;
            err_d   = (beats_inc != exp_beats);
          end else begin
            err_d   = (beats_inc == exp_beats);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      prio_q  <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == S_BUSY) begin
      oreq          = cur_req;
      iresps[sel_q] = oresp;
    end
  end

  assign busy         = (state_q == S_BUSY);
  assign grant_idx    = sel_q;
  assign protocol_err = err_q;

endmodule
